// File: rtl/disp_pkg.sv
// Shared definitions for the 4-digit 7-segment display scanner.
//   NUM_DIGITS : number of multiplexed digits
//   NIB_W      : width of one hex nibble
//   AN_OFF     : anode pattern with every digit dark (anodes are active-low)
//   disp_rec_t : one complete display image (digits, decimal points, blanks)
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  typedef struct packed {
    logic [NUM_DIGITS*NIB_W-1:0] digits;
    logic [NUM_DIGITS-1:0]       dp;
    logic [NUM_DIGITS-1:0]       blank;
  } disp_rec_t;

endpackage

// File: rtl/disp_prescaler.sv
// Terminal-count prescaler: counts 0..DIV-1 and wraps.
//   clk   : system clock
//   reset : synchronous, active-high reset (count returns to 0)
//   cnt   : current count, used by the parent for the guard-window compare
//   tick  : high during the cycle in which cnt == DIV-1
module disp_prescaler #(
  parameter int unsigned DIV = 4,
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  always_comb begin
    tick = (cnt == CNT_W'(DIV - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/disp_scan_4dig.sv
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// New display data is staged in a pending buffer and copied to the shadow
// image only at the frame boundary, so a frame never mixes old and new data.
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   load       : one-cycle strobe capturing digits_in / dp_in / blank_in
//   digits_in  : four nibbles, [3:0] is digit 0 (rightmost)
//   dp_in      : decimal-point request per digit, active-high
//   blank_in   : forced blank per digit, active-high
//   hex        : nibble for the downstream decoder (tracks the scanned digit)
//   dp_n       : decimal point, active-low
//   an         : anode enables, active-low
//   upd_done   : one-cycle pulse when the shadow image takes new data
//   frame_tick : one-cycle pulse when the scan wraps from digit 3 to digit 0
// Legal parameters: REFRESH_DIV >= 4, 1 <= GUARD < REFRESH_DIV.
module disp_scan_4dig
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 2,
  parameter bit          LZB         = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [3:0]  hex,
  output logic        dp_n,
  output logic [3:0]  an,
  output logic        upd_done,
  output logic        frame_tick
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [1:0]  LAST_SEL = 2'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [1:0]       sel_q;
  logic             pending_q;
  disp_rec_t        buf_q, shadow_q, in_rec;
  logic             frame_end;

  logic [NIB_W-1:0]      nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  dark;
  logic [3:0]            an_d;
  logic [3:0]            hex_d;
  logic                  dp_n_d;

  disp_prescaler #(
    .DIV(REFRESH_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .cnt  (cnt),
    .tick (tick)
  );

  always_comb begin
    in_rec    = '{digits: digits_in, dp: dp_in, blank: blank_in};
    frame_end = tick && (sel_q == LAST_SEL);
  end

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nib[k] = shadow_q.digits[k*NIB_W +: NIB_W];
    end
    // A digit is a leading zero when it and every higher digit are zero;
    // digit 0 always stays lit so a value of zero still shows "0".
    lz_blank = '0;
    if (LZB) begin
      lz_blank[3] = (nib[3] == '0);
      lz_blank[2] = lz_blank[3] && (nib[2] == '0);
      lz_blank[1] = lz_blank[2] && (nib[1] == '0);
    end
    dark   = (cnt < CNT_W'(GUARD)) || shadow_q.blank[sel_q] || lz_blank[sel_q];
    // hex follows sel even when dark so the decoder settles during the guard.
    hex_d  = nib[sel_q];
    an_d   = AN_OFF;
    dp_n_d = 1'b1;
    if (!dark) begin
      an_d   = ~(4'b0001 << sel_q);
      dp_n_d = ~shadow_q.dp[sel_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q      <= '0;
      pending_q  <= 1'b0;
      buf_q      <= '0;
      shadow_q   <= '0;
      upd_done   <= 1'b0;
      frame_tick <= 1'b0;
      an         <= AN_OFF;
      hex        <= '0;
      dp_n       <= 1'b1;
    end else begin
      if (tick) begin
        sel_q <= sel_q + 2'd1;
      end
      frame_tick <= frame_end;
      upd_done   <= 1'b0;
      // A load landing on the boundary goes straight to the shadow.
      if (frame_end && (load || pending_q)) begin
        shadow_q  <= load ? in_rec : buf_q;
        pending_q <= 1'b0;
        upd_done  <= 1'b1;
      end else if (load) begin
        buf_q     <= in_rec;
        pending_q <= 1'b1;
      end
      an   <= an_d;
      hex  <= hex_d;
      dp_n <= dp_n_d;
    end
  end

endmodule
